// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared types for the in-order issue controller: operation payload and ALU function codes.
package pipe_pkg;

    localparam int unsigned REG_W  = 4;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned FUNC_W = 2;

    localparam logic [FUNC_W-1:0] FUNC_ADD = 2'b00;
    localparam logic [FUNC_W-1:0] FUNC_SUB = 2'b01;
    localparam logic [FUNC_W-1:0] FUNC_AND = 2'b10;
    localparam logic [FUNC_W-1:0] FUNC_XOR = 2'b11;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } op_t;

    localparam int unsigned OP_W = $bits(op_t);

endpackage

// File: rtl/pipe_issue_ctrl_if.sv
// Operation intake handshake and registered issue bundle toward the pipeline.
interface pipe_issue_ctrl_if;
    import pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [REG_W-1:0]  in_rd;
    logic [FUNC_W-1:0] in_func;
    logic [ADDR_W-1:0] in_addr;

    logic              iss_valid;
    logic [REG_W-1:0]  iss_rs1;
    logic [REG_W-1:0]  iss_rs2;
    logic [REG_W-1:0]  iss_rd;
    logic [FUNC_W-1:0] iss_func;
    logic [ADDR_W-1:0] iss_addr;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        input  in_ready,
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        output in_ready,
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_func, iss_addr
    );

endinterface

// File: rtl/pipe_issue_ctrl_op_fifo.sv
// Operation queue with extra-MSB wrap pointers; flush empties it without touching storage.
module op_fifo
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk_1,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  op_t  wdata,
    output op_t  rdata,
    output logic full,
    output logic empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    op_t           mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk_1) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// In-order issue controller: queues ops, holds RAW-dependent heads until the producer
// has written back, and keeps stall/issue statistics.
module pipe_issue_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WB_LAT = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    pipe_issue_ctrl_if.slave bus,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] issue_cnt
);
    op_t  in_op;
    op_t  head;
    logic full;
    logic empty;
    logic push;
    logic issue;
    logic hazard;
    logic stall;

    logic [WB_LAT-1:0] sb_valid;
    logic [REG_W-1:0]  sb_rd [WB_LAT];

    assign in_op = '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
                     func: bus.in_func, addr: bus.in_addr};

    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full && !flush;
    assign issue        = !empty && en && !flush && !hazard;
    assign stall        = !empty && en && hazard;
    assign busy         = !empty || (|sb_valid);

    op_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_1 (clk_1),
        .rst   (rst),
        .push  (push),
        .pop   (issue),
        .flush (flush),
        .wdata (in_op),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Head sources against every destination still waiting for writeback.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < WB_LAT; i++) begin
            if (sb_valid[i] && ((sb_rd[i] == head.rs1) || (sb_rd[i] == head.rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    // Fixed-latency in-flight tracker; shifts every cycle regardless of en/flush.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            for (int i = 0; i < WB_LAT; i++) sb_rd[i] <= '0;
        end else begin
            sb_valid[0] <= issue;
            sb_rd[0]    <= head.rd;
            for (int i = 1; i < WB_LAT; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_rd[i]    <= sb_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            bus.iss_valid <= 1'b0;
            bus.iss_rs1   <= '0;
            bus.iss_rs2   <= '0;
            bus.iss_rd    <= '0;
            bus.iss_func  <= '0;
            bus.iss_addr  <= '0;
        end else begin
            bus.iss_valid <= issue;
            if (issue) begin
                bus.iss_rs1  <= head.rs1;
                bus.iss_rs2  <= head.rs2;
                bus.iss_rd   <= head.rd;
                bus.iss_func <= head.func;
                bus.iss_addr <= head.addr;
            end
        end
    end

    // Stall counter saturates; issue counter wraps.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            issue_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: vector table, directed corner sequences and random traffic
// against a register-ready-time reference model.
module tb_pipe_issue_ctrl;
    import pipe_pkg::*;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned WB_LAT  = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          CNT_MOD = (1 << CNT_W);

    logic             clk_1;
    logic             rst;
    logic             en;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] issue_cnt;

    pipe_issue_ctrl_if ifc ();

    pipe_issue_ctrl #(.DEPTH(DEPTH), .WB_LAT(WB_LAT), .CNT_W(CNT_W)) dut (
        .clk_1     (clk_1),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .bus       (ifc.slave),
        .busy      (busy),
        .stall_cnt (stall_cnt),
        .issue_cnt (issue_cnt)
    );

    initial clk_1 = 1'b0;
    always #5 clk_1 = ~clk_1;

    int tests;
    int fails;

    // Reference model: queue of ops, and per register the first edge at which it is readable.
    op_t  mq[$];
    int   ready_at [16];
    int   n_edge;
    int   stall_raw;
    int   issued;
    op_t  exp_iss;
    logic exp_iv;

    typedef struct {
        logic       v;
        logic [3:0] rs1, rs2, rd;
        logic       exp_iv;
        logic [3:0] exp_rd;
        logic       exp_busy;
        int         exp_stall;
        int         exp_issue;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic model_busy();
        logic b;
        b = (mq.size() != 0);
        for (int r = 0; r < 16; r++) if (ready_at[r] > n_edge) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int r = 0; r < 16; r++) ready_at[r] = 0;
        stall_raw = 0;
        issued    = 0;
        exp_iss   = '0;
        exp_iv    = 1'b0;
    endtask

    task automatic check_outputs();
        chk("iss_valid", 32'(ifc.iss_valid), 32'(exp_iv));
        chk("iss_fields", 32'({ifc.iss_rs1, ifc.iss_rs2, ifc.iss_rd, ifc.iss_func, ifc.iss_addr}),
            32'(exp_iss));
        chk("busy", 32'(busy), 32'(model_busy()));
        chk("stall_cnt", 32'(stall_cnt), 32'((stall_raw > CNT_MAX) ? CNT_MAX : stall_raw));
        chk("issue_cnt", 32'(issue_cnt), 32'(issued % CNT_MOD));
    endtask

    task automatic drive(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                         input logic [3:0] rd, input logic [1:0] fn, input logic [7:0] a);
        ifc.in_valid = v;
        ifc.in_rs1   = r1;
        ifc.in_rs2   = r2;
        ifc.in_rd    = rd;
        ifc.in_func  = fn;
        ifc.in_addr  = a;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 4'd0, FUNC_ADD, 8'd0);
    endtask

    // One clock edge: predict from pre-edge inputs, advance, then compare.
    task automatic step();
        op_t  cur;
        op_t  h;
        logic v, e, f, emp, hz, iss, psh;
        v   = ifc.in_valid;
        e   = en;
        f   = flush;
        cur = '{rs1: ifc.in_rs1, rs2: ifc.in_rs2, rd: ifc.in_rd, func: ifc.in_func, addr: ifc.in_addr};
        emp = (mq.size() == 0);
        chk("in_ready", 32'(ifc.in_ready), 32'(mq.size() < DEPTH));
        hz = 1'b0;
        h  = '0;
        if (!emp) begin
            h  = mq[0];
            hz = (ready_at[h.rs1] > n_edge) || (ready_at[h.rs2] > n_edge);
        end
        iss = !emp && e && !f && !hz;
        psh = v && (mq.size() < DEPTH) && !f;
        @(posedge clk_1);
        #1;
        if (!emp && e && hz) stall_raw++;
        if (f) begin
            mq.delete();
        end else begin
            if (iss) begin
                h = mq.pop_front();
                exp_iss = h;
                issued++;
                ready_at[h.rd] = n_edge + int'(WB_LAT) + 1;
            end
            if (psh) mq.push_back(cur);
        end
        exp_iv = iss;
        n_edge++;
        check_outputs();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        idle();
        en    = 1'b0;
        flush = 1'b0;
        rst   = 1'b1;
        #2;
        model_reset();
        check_outputs();
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk_1);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                                input logic [3:0] rd, input logic eiv, input logic [3:0] erd,
                                input logic eb, input int es, input int ei);
        vec_t t;
        t.v = v; t.rs1 = r1; t.rs2 = r2; t.rd = rd;
        t.exp_iv = eiv; t.exp_rd = erd; t.exp_busy = eb; t.exp_stall = es; t.exp_issue = ei;
        return t;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tests  = 0;
        fails  = 0;
        n_edge = 0;
        rst    = 1'b1;
        en     = 1'b0;
        flush  = 1'b0;
        idle();
        model_reset();

        // Independent ops, RAW pair, self-dependence; expected values after each edge.
        tbl[0]  = mk(1, 1, 2, 3, 0, 0, 1, 0, 0);
        tbl[1]  = mk(1, 4, 5, 6, 1, 3, 1, 0, 1);
        tbl[2]  = mk(1, 7, 8, 9, 1, 6, 1, 0, 2);
        tbl[3]  = mk(0, 0, 0, 0, 1, 9, 1, 0, 3);
        tbl[4]  = mk(0, 0, 0, 0, 0, 9, 1, 0, 3);
        tbl[5]  = mk(0, 0, 0, 0, 0, 9, 0, 0, 3);
        tbl[6]  = mk(1, 1, 2, 3, 0, 9, 1, 0, 3);
        tbl[7]  = mk(1, 3, 4, 5, 1, 3, 1, 0, 4);
        tbl[8]  = mk(0, 0, 0, 0, 0, 3, 1, 1, 4);
        tbl[9]  = mk(0, 0, 0, 0, 0, 3, 1, 2, 4);
        tbl[10] = mk(0, 0, 0, 0, 1, 5, 1, 2, 5);
        tbl[11] = mk(0, 0, 0, 0, 0, 5, 1, 2, 5);
        tbl[12] = mk(0, 0, 0, 0, 0, 5, 0, 2, 5);
        tbl[13] = mk(1, 3, 3, 3, 0, 5, 1, 2, 5);
        tbl[14] = mk(0, 0, 0, 0, 1, 3, 1, 2, 6);
        tbl[15] = mk(0, 0, 0, 0, 0, 3, 1, 2, 6);
        tbl[16] = mk(0, 0, 0, 0, 0, 3, 0, 2, 6);

        #12;
        check_outputs();
        chk("init_in_ready", 32'(ifc.in_ready), 32'd1);
        @(negedge clk_1);
        rst = 1'b0;

        en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, FUNC_SUB, 8'(8'h10 + i));
            step();
            chk($sformatf("vec%0d_iss_valid", i), 32'(ifc.iss_valid), 32'(tbl[i].exp_iv));
            chk($sformatf("vec%0d_iss_rd", i), 32'(ifc.iss_rd), 32'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].exp_stall));
            chk($sformatf("vec%0d_issue", i), 32'(issue_cnt), 32'(tbl[i].exp_issue));
        end

        // Fill with en low, fifth offer refused, then drain in order.
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i), 4'(i), 4'(8 + i), 2'(i), 8'(8'hA0 + i));
            if (i == 4) chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
            step();
        end
        idle();
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_valid", 32'(ifc.iss_valid), 32'd1);
            chk("drain_addr", 32'(ifc.iss_addr), 32'(8'hA0 + k));
        end
        for (int k = 0; k < 3; k++) step();

        // Flush with two queued, one in flight and a simultaneous push.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd1, 4'd2, 4'(4 + i), FUNC_AND, 8'(8'hC0 + i));
            step();
        end
        idle();
        en = 1'b1;
        step();
        chk("pre_flush_issue", 32'(ifc.iss_valid), 32'd1);
        drive(1'b1, 4'd1, 4'd2, 4'd7, FUNC_XOR, 8'hCF);
        flush = 1'b1;
        chk("flush_in_ready", 32'(ifc.in_ready), 32'd1);
        step();
        flush = 1'b0;
        idle();
        chk("flush_no_issue", 32'(ifc.iss_valid), 32'd0);
        chk("flush_busy_inflight", 32'(busy), 32'd1);
        step();
        chk("flush_busy_clear", 32'(busy), 32'd0);
        step();
        chk("flush_dropped", 32'(ifc.iss_valid), 32'd0);

        // Dependent chain to drive the stall counter into saturation.
        begin
            logic [3:0] prev;
            logic [3:0] nxt;
            prev = 4'd13;
            for (int c = 0; c < 200 && stall_raw < 22; c++) begin
                nxt = (prev == 4'd13) ? 4'd14 : 4'd13;
                drive(1'b1, prev, prev, nxt, FUNC_ADD, 8'(c));
                if (ifc.in_ready) prev = nxt;
                step();
            end
            idle();
            chk("stall_sat", 32'(stall_cnt), 32'(CNT_MAX));
            for (int k = 0; k < 12; k++) step();
        end

        // Reset mid-stream with queued work.
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd0, 4'd1, 4'(2 + i), FUNC_ADD, 8'(i));
            step();
        end
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_issue", 32'(issue_cnt), 32'd0);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_no_issue", 32'(ifc.iss_valid), 32'd0);
        end

        // Random traffic with a small register range to provoke hazards.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(199) == 0) begin
                do_reset();
            end
            en    = ($urandom_range(9) < 8);
            flush = ($urandom_range(19) == 0);
            drive(($urandom_range(9) < 6), 4'($urandom_range(3)), 4'($urandom_range(3)),
                  4'($urandom_range(3)), 2'($urandom_range(3)), 8'($urandom_range(255)));
            step();
        end
        flush = 1'b0;
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
